user_strm_loopback: RTL and testbench
=====================================

USER_STRM_LOOPBACK -- requirements
Module: user_strm_loopback

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the number of 64-bit entries in the internal buffer (power of two, 4..256).
REQ-002 The block SHALL have parameter REG_BASE, default 20'h00000, meaning the user register window base address.
REQ-003 The block SHALL have port i_user_clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have the following ports: i_user_data in 32, i_user_addr in 20, i_user_wr_req in 1, i_user_rd_req in 1, o_user_data out 32, o_user_rd_ack out 1 (register i/f).
REQ-006 The block SHALL have the following ports: i_pcie_str_data_valid in 1, i_pcie_str_data in 64, o_pcie_str_ack out 1 (inbound stream).
REQ-007 The block SHALL have the following ports: o_pcie_str_data_valid out 1, o_pcie_str_data out 64, i_pcie_str_ack in 1 (outbound stream).
REQ-008 The block SHALL have the following ports: o_intr_req out 1, i_intr_ack in 1 (interrupt).

Function
REQ-009 A stream word SHALL transfer on any rising edge where valid and ack are both high, on either stream.
REQ-010 o_pcie_str_ack SHALL equal i_pcie_str_data_valid AND enable AND NOT fifo_full, combinationally.
REQ-011 A push into a full FIFO SHALL never occur; a pop in the same cycle SHALL NOT free space for that cycle's push.
REQ-012 o_pcie_str_data_valid SHALL be high whenever the FIFO is not empty and the state is RUN; head data SHALL be held stable until accepted.
REQ-013 Latency from inbound transfer to o_pcie_str_data_valid SHALL be 1 cycle when the FIFO is empty.
REQ-014 The registers SHALL be at REG_BASE+0x0 CTRL (bit0 enable, bit1 soft clear, self-clearing), +0x4 LEN (32-bit words-per-interrupt), +0x8 COUNT (read-only outbound words since last interrupt), +0xC KEY (32-bit), +0x10 STATUS (read-only: [8:0] fill level, bit16 full, bit17 empty, bits19:18 state).
REQ-015 o_user_rd_ack SHALL pulse 1 cycle after i_user_rd_req, with o_user_data valid in that same cycle; unmapped reads SHALL return 32'h0.
REQ-016 The FSM SHALL have states IDLE, RUN, INTR.
REQ-017 The FSM SHALL transition IDLE->RUN when enable=1, and RUN->IDLE when enable=0; the FIFO contents SHALL be retained.
REQ-018 The FSM SHALL transition RUN->INTR on an outbound transfer that makes COUNT+1 equal LEN (LEN≠0); o_intr_req SHALL assert the next cycle.
REQ-019 In INTR, o_pcie_str_data_valid SHALL be 0; inbound SHALL continue while not full.
REQ-020 INTR->RUN (or IDLE if enable=0) SHALL occur on i_intr_ack; o_intr_req SHALL deassert and COUNT SHALL clear the same edge.
REQ-021 When LEN=0, no interrupt SHALL be raised; COUNT SHALL wrap at 2^32.
REQ-022 Soft clear SHALL empty the FIFO, zero COUNT, drop o_intr_req, and return the FSM to IDLE in one cycle; simultaneous stream transfers SHALL be discarded.
REQ-023 A register write and a read to the same address in the same cycle SHALL return the old value.

Reset
REQ-024 When i_rst=0 at a clock edge, all outputs SHALL be 0, the FIFO empty, CTRL/LEN/COUNT/KEY 0, FSM IDLE.
REQ-025 Reset mid-transfer SHALL discard all buffered data without any handshake being completed.

Configuration
REQ-026 With STRM_XOR_EN defined, o_pcie_str_data SHALL equal FIFO head XOR {KEY,KEY}, combinationally at the output.
REQ-027 Without STRM_XOR_EN, data SHALL pass unchanged; KEY writes SHALL be ignored and KEY SHALL read 0.

Structure
REQ-028 A shared package user_strm_pkg SHALL hold register offsets, the FSM state encoding, and the STATUS bit positions.
REQ-029 The buffer SHALL be the sub-module strm_sync_fifo (single clock, parameterised width/depth, full/empty/level outputs).

Verification
REQ-030 The bench SHALL cover: enable=1, LEN=4, push 4 words 0x1..0x4 with i_pcie_str_ack=1 -> outputs 0x1..0x4 in order, o_intr_req=1 after the 4th, COUNT=4; i_intr_ack -> COUNT=0, RUN.
REQ-031 The bench SHALL cover: i_pcie_str_ack=0, push FIFO_DEPTH+2 words -> o_pcie_str_ack low after 16 accepts, STATUS full=1, level=16.
REQ-032 The bench SHALL cover: STRM_XOR_EN, KEY=0xFFFF0000, in 64'h0 -> out 64'hFFFF0000FFFF0000.
REQ-033 The bench SHALL cover: soft clear with 5 words buffered and o_intr_req=1 -> next cycle empty=1, o_intr_req=0, state IDLE.
REQ-034 The bench SHALL cover: i_rst=0 for 1 cycle while valid/ack active -> all outputs 0, read of every register returns 0 after 1-cycle rd_ack.

Source files
------------

// File: rtl/user_strm_pkg.sv
// Shared definitions for the user stream loopback block: register offsets,
// CTRL/STATUS bit positions, FSM state encoding and a STATUS packing helper.
package user_strm_pkg;

    // Register offsets relative to REG_BASE
    localparam logic [19:0] REG_CTRL_OFF   = 20'h00000;
    localparam logic [19:0] REG_LEN_OFF    = 20'h00004;
    localparam logic [19:0] REG_COUNT_OFF  = 20'h00008;
    localparam logic [19:0] REG_KEY_OFF    = 20'h0000C;
    localparam logic [19:0] REG_STATUS_OFF = 20'h00010;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    // STATUS bit positions
    localparam int unsigned STAT_LEVEL_LSB = 0;
    localparam int unsigned STAT_LEVEL_W   = 9;
    localparam int unsigned STAT_FULL_BIT  = 16;
    localparam int unsigned STAT_EMPTY_BIT = 17;
    localparam int unsigned STAT_STATE_LSB = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_INTR = 2'd2
    } strm_state_e;

    // Assemble the STATUS register word from its fields
    function automatic logic [31:0] pack_status(
        input logic [8:0]  level,
        input logic        full,
        input logic        empty,
        input strm_state_e st
    );
        logic [31:0] s;
        s = '0;
        s[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
        s[STAT_FULL_BIT]                  = full;
        s[STAT_EMPTY_BIT]                 = empty;
        s[STAT_STATE_LSB +: 2]            = st;
        return s;
    endfunction

endpackage

// File: rtl/strm_sync_fifo.sv
// Single-clock FIFO with synchronous clear and full/empty/level outputs.
// The head word is presented combinationally on rd_data.
module strm_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer/level; clear wins over any simultaneous push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (rst_n && do_push && !clr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/user_strm_loopback.sv
// User stream loopback: inbound 64-bit stream is buffered in a FIFO and
// replayed on the outbound stream, with a register window for control,
// words-per-interrupt counting and a status view.
// Optional feature: define STRM_XOR_EN to XOR outbound data with {KEY,KEY};
// without it KEY is ignored on write and reads as zero.
module user_strm_loopback #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [19:0] REG_BASE   = 20'h00000
) (
    input  logic        i_user_clk,
    input  logic        i_rst,
    input  logic [31:0] i_user_data,
    input  logic [19:0] i_user_addr,
    input  logic        i_user_wr_req,
    input  logic        i_user_rd_req,
    output logic [31:0] o_user_data,
    output logic        o_user_rd_ack,
    input  logic        i_pcie_str_data_valid,
    input  logic [63:0] i_pcie_str_data,
    output logic        o_pcie_str_ack,
    output logic        o_pcie_str_data_valid,
    output logic [63:0] o_pcie_str_data,
    input  logic        i_pcie_str_ack,
    output logic        o_intr_req,
    input  logic        i_intr_ack
);

    import user_strm_pkg::*;

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [19:0] ADDR_CTRL   = REG_BASE + REG_CTRL_OFF;
    localparam logic [19:0] ADDR_LEN    = REG_BASE + REG_LEN_OFF;
    localparam logic [19:0] ADDR_COUNT  = REG_BASE + REG_COUNT_OFF;
    localparam logic [19:0] ADDR_KEY    = REG_BASE + REG_KEY_OFF;
    localparam logic [19:0] ADDR_STATUS = REG_BASE + REG_STATUS_OFF;

    strm_state_e state_q, state_d;
    logic        en_q, en_d;
    logic [31:0] len_q, len_d;
    logic [31:0] count_q, count_d;
    logic        rd_ack_q, rd_ack_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] key_val;

    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [63:0]   fifo_head;

    logic        wr_ctrl;
    logic        soft_clr;
    logic        in_ack;
    logic        out_valid;
    logic        out_xfer;
    logic [31:0] count_inc;

    assign wr_ctrl   = i_user_wr_req && (i_user_addr == ADDR_CTRL);
    assign soft_clr  = wr_ctrl && i_user_data[CTRL_CLR_BIT];
    assign count_inc = count_q + 32'd1;

    // Both handshakes are gated by reset so no transfer can complete while held
    assign in_ack    = i_rst && i_pcie_str_data_valid && en_q && !fifo_full;
    assign out_valid = i_rst && (state_q == ST_RUN) && !fifo_empty;
    assign out_xfer  = out_valid && i_pcie_str_ack;

    assign o_pcie_str_ack        = in_ack;
    assign o_pcie_str_data_valid = out_valid;
    assign o_intr_req            = (state_q == ST_INTR);
    assign o_user_rd_ack         = rd_ack_q;
    assign o_user_data           = rd_data_q;

    strm_sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_user_clk),
        .rst_n   (i_rst),
        .clr     (soft_clr),
        .push    (in_ack),
        .wr_data (i_pcie_str_data),
        .pop     (out_xfer),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

`ifdef STRM_XOR_EN
    logic [31:0] key_q, key_d;

    // KEY register write
    always_comb begin
        key_d = key_q;
        if (i_user_wr_req && (i_user_addr == ADDR_KEY)) key_d = i_user_data;
    end

    // KEY register
    always_ff @(posedge i_user_clk) begin
        if (!i_rst) key_q <= '0;
        else        key_q <= key_d;
    end

    assign key_val = key_q;

    // Outbound data: head scrambled with the key, forced to zero when empty
    always_comb begin
        o_pcie_str_data = '0;
        if (!fifo_empty) o_pcie_str_data = fifo_head ^ {key_q, key_q};
    end
`else
    assign key_val = '0;

    // Outbound data: head passed through, forced to zero when empty
    always_comb begin
        o_pcie_str_data = '0;
        if (!fifo_empty) o_pcie_str_data = fifo_head;
    end
`endif

    // FSM next state; soft clear overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (out_xfer && (len_q != '0) && (count_inc == len_q)) state_d = ST_INTR;
                else if (!en_q)                                        state_d = ST_IDLE;
            end
            ST_INTR: begin
                if (i_intr_ack) state_d = en_q ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (soft_clr) state_d = ST_IDLE;
    end

    // Outbound word counter; cleared by soft clear or interrupt acknowledge
    always_comb begin
        count_d = count_q;
        if (soft_clr)                             count_d = '0;
        else if ((state_q == ST_INTR) && i_intr_ack) count_d = '0;
        else if (out_xfer)                        count_d = count_inc;
    end

    // CTRL enable and LEN register writes
    always_comb begin
        en_d  = en_q;
        len_d = len_q;
        if (wr_ctrl) en_d = i_user_data[CTRL_EN_BIT];
        if (i_user_wr_req && (i_user_addr == ADDR_LEN)) len_d = i_user_data;
    end

    // Read decode from current register values, so a same-cycle write is not visible
    always_comb begin
        rd_ack_d  = i_user_rd_req;
        rd_data_d = '0;
        if (i_user_rd_req) begin
            case (i_user_addr)
                ADDR_CTRL:   rd_data_d = {31'b0, en_q};
                ADDR_LEN:    rd_data_d = len_q;
                ADDR_COUNT:  rd_data_d = count_q;
                ADDR_KEY:    rd_data_d = key_val;
                ADDR_STATUS: rd_data_d = pack_status(9'(fifo_level), fifo_full, fifo_empty, state_q);
                default:     rd_data_d = '0;
            endcase
        end
    end

    // Control, FSM and read-response registers
    always_ff @(posedge i_user_clk) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            len_q     <= '0;
            count_q   <= '0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            len_q     <= len_d;
            count_q   <= count_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_user_strm_loopback.sv
// Self-checking bench for user_strm_loopback: a queue-based model predicts the
// handshakes, outbound data, interrupt and register reads every cycle, and
// directed scenarios pin the model with hand-computed literal values.
module tb_user_strm_loopback;

    localparam int          DEPTH = 16;
    localparam logic [19:0] BASE  = 20'h01000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_user_data;
    logic [19:0] i_user_addr;
    logic        i_user_wr_req;
    logic        i_user_rd_req;
    logic [31:0] o_user_data;
    logic        o_user_rd_ack;
    logic        i_pcie_str_data_valid;
    logic [63:0] i_pcie_str_data;
    logic        o_pcie_str_ack;
    logic        o_pcie_str_data_valid;
    logic [63:0] o_pcie_str_data;
    logic        i_pcie_str_ack;
    logic        o_intr_req;
    logic        i_intr_ack;

    always #5 clk = ~clk;

    user_strm_loopback #(
        .FIFO_DEPTH (DEPTH),
        .REG_BASE   (BASE)
    ) dut (
        .i_user_clk            (clk),
        .i_rst                 (i_rst),
        .i_user_data           (i_user_data),
        .i_user_addr           (i_user_addr),
        .i_user_wr_req         (i_user_wr_req),
        .i_user_rd_req         (i_user_rd_req),
        .o_user_data           (o_user_data),
        .o_user_rd_ack         (o_user_rd_ack),
        .i_pcie_str_data_valid (i_pcie_str_data_valid),
        .i_pcie_str_data       (i_pcie_str_data),
        .o_pcie_str_ack        (o_pcie_str_ack),
        .o_pcie_str_data_valid (o_pcie_str_data_valid),
        .o_pcie_str_data       (o_pcie_str_data),
        .i_pcie_str_ack        (i_pcie_str_ack),
        .o_intr_req            (o_intr_req),
        .i_intr_ack            (i_intr_ack)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mq[$];
    bit          m_en    = 1'b0;
    bit          m_run   = 1'b0;
    bit          m_intr  = 1'b0;
    logic [31:0] m_len   = 32'h0;
    logic [31:0] m_count = 32'h0;
    logic [31:0] m_key   = 32'h0;
    bit          e_rd_ack  = 1'b0;
    logic [31:0] e_rd_data = 32'h0;

    function automatic bit exp_out_valid();
        return i_rst && m_run && !m_intr && (mq.size() > 0);
    endfunction

    function automatic bit exp_in_ack();
        return i_rst && i_pcie_str_data_valid && m_en && (mq.size() < DEPTH);
    endfunction

    function automatic logic [63:0] exp_head();
`ifdef STRM_XOR_EN
        return mq[0] ^ {m_key, m_key};
`else
        return mq[0];
`endif
    endfunction

    function automatic logic [31:0] exp_reg(input logic [19:0] a);
        logic [31:0] st;
        st = 32'h0;
        if (a == BASE)          return {31'b0, m_en};
        if (a == BASE + 20'h4)  return m_len;
        if (a == BASE + 20'h8)  return m_count;
        if (a == BASE + 20'hC)  return m_key;
        if (a == BASE + 20'h10) begin
            st[8:0]   = 9'(mq.size());
            st[16]    = (mq.size() == DEPTH);
            st[17]    = (mq.size() == 0);
            st[19:18] = m_intr ? 2'd2 : (m_run ? 2'd1 : 2'd0);
            return st;
        end
        return 32'h0;
    endfunction

    always @(posedge clk) begin : model
        bit ox, ix, clr, was_intr, was_run;
        if (!i_rst) begin
            mq.delete();
            m_en = 0; m_run = 0; m_intr = 0;
            m_len = 0; m_count = 0; m_key = 0;
            e_rd_ack = 0; e_rd_data = 0;
        end else begin
            e_rd_ack  = i_user_rd_req;
            e_rd_data = i_user_rd_req ? exp_reg(i_user_addr) : 32'h0;
            ox  = exp_out_valid() && i_pcie_str_ack;
            ix  = exp_in_ack();
            clr = i_user_wr_req && (i_user_addr == BASE) && i_user_data[1];
            was_intr = m_intr;
            was_run  = m_run;
            if (clr) begin
                mq.delete();
                m_count = 0; m_intr = 0; m_run = 0;
            end else begin
                if (ox) begin void'(mq.pop_front()); m_count = m_count + 1; end
                if (ix) mq.push_back(i_pcie_str_data);
                if (was_intr) begin
                    if (i_intr_ack) begin m_intr = 0; m_count = 0; m_run = m_en; end
                end else if (was_run) begin
                    if (ox && m_len != 0 && m_count == m_len) m_intr = 1;
                    else if (!m_en) m_run = 0;
                end else begin
                    m_run = m_en;
                end
            end
            if (i_user_wr_req) begin
                if (i_user_addr == BASE)          m_en  = i_user_data[0];
                if (i_user_addr == BASE + 20'h4)  m_len = i_user_data;
`ifdef STRM_XOR_EN
                if (i_user_addr == BASE + 20'hC)  m_key = i_user_data;
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [63:0] out_log[$];
    int          acc_cnt = 0;

    always @(negedge clk) begin
        check("in_ack",    64'(o_pcie_str_ack),        64'(exp_in_ack()));
        check("out_valid", 64'(o_pcie_str_data_valid), 64'(exp_out_valid()));
        if (exp_out_valid()) check("out_data", o_pcie_str_data, exp_head());
        check("intr_req",  64'(o_intr_req),            64'(m_intr));
        check("rd_ack",    64'(o_user_rd_ack),         64'(e_rd_ack));
        if (e_rd_ack) check("rd_data", 64'(o_user_data), 64'(e_rd_data));
        if (o_pcie_str_data_valid && i_pcie_str_ack) out_log.push_back(o_pcie_str_data);
        if (o_pcie_str_ack) acc_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [19:0] off, input logic [31:0] d);
        i_user_wr_req = 1'b1;
        i_user_addr   = BASE + off;
        i_user_data   = d;
        tick();
        i_user_wr_req = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [19:0] off, input logic [31:0] exp);
        i_user_rd_req = 1'b1;
        i_user_addr   = BASE + off;
        tick();
        i_user_rd_req = 1'b0;
        check({name, "_ack"}, 64'(o_user_rd_ack), 64'(1'b1));
        check(name, 64'(o_user_data), 64'(exp));
    endtask

    task automatic push_words(input int n, input logic [63:0] base);
        for (int k = 0; k < n; k++) begin
            i_pcie_str_data_valid = 1'b1;
            i_pcie_str_data       = base + 64'(k);
            tick();
        end
    endtask

    task automatic wait_intr(input int budget);
        for (int i = 0; i < budget && !o_intr_req; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b0;
        i_user_data = '0; i_user_addr = '0;
        i_user_wr_req = 1'b0; i_user_rd_req = 1'b0;
        i_pcie_str_data_valid = 1'b0; i_pcie_str_data = '0;
        i_pcie_str_ack = 1'b0; i_intr_ack = 1'b0;
        tick(); tick();
        i_rst = 1'b1;

        // Reset state
        check("rst_out_valid", 64'(o_pcie_str_data_valid), 64'(0));
        check("rst_intr",      64'(o_intr_req), 64'(0));
        rd_expect("rst_status", 20'h10, 32'h0002_0000);

        // Same-cycle write and read of LEN returns the old value
        wr(20'h4, 32'd4);
        i_user_wr_req = 1'b1; i_user_rd_req = 1'b1;
        i_user_addr = BASE + 20'h4; i_user_data = 32'd9;
        tick();
        i_user_wr_req = 1'b0; i_user_rd_req = 1'b0;
        check("wr_rd_same_old", 64'(o_user_data), 64'(32'd4));
        wr(20'h4, 32'd4);

        // LEN=4 loopback of 1..4 with interrupt
        wr(20'h0, 32'h1);
        i_pcie_str_ack = 1'b1;
        tick();
        out_log.delete();
        push_words(4, 64'h1);
        i_pcie_str_data_valid = 1'b0;
        wait_intr(20);
        check("t1_intr", 64'(o_intr_req), 64'(1));
        check("t1_nwords", 64'(out_log.size()), 64'(4));
        for (int k = 0; k < 4 && k < out_log.size(); k++)
            check("t1_word", out_log[k], 64'(k + 1));
        check("t1_valid_in_intr", 64'(o_pcie_str_data_valid), 64'(0));
        rd_expect("t1_count", 20'h8, 32'd4);
        i_intr_ack = 1'b1;
        tick();
        i_intr_ack = 1'b0;
        check("t1_intr_clr", 64'(o_intr_req), 64'(0));
        rd_expect("t1_count_clr", 20'h8, 32'd0);
        rd_expect("t1_status_run", 20'h10, 32'h0006_0000);

        // Fill past capacity with outbound stalled
        i_pcie_str_ack = 1'b0;
        acc_cnt = 0;
        push_words(DEPTH + 2, 64'hA000);
        check("t2_accepts", 64'(acc_cnt), 64'(16));
        check("t2_ack_full", 64'(o_pcie_str_ack), 64'(0));
        rd_expect("t2_status_full", 20'h10, 32'h0005_0010);
        i_pcie_str_data_valid = 1'b0;

        // Soft clear with 5 buffered and interrupt pending
        wr(20'h0, 32'h2);
        wr(20'h0, 32'h1);
        tick();
        push_words(9, 64'hB000);
        i_pcie_str_data_valid = 1'b0;
        i_pcie_str_ack = 1'b1;
        wait_intr(20);
        check("t3_intr", 64'(o_intr_req), 64'(1));
        rd_expect("t3_status_intr", 20'h10, 32'h0008_0005);
        wr(20'h0, 32'h2);
        check("t3_intr_dropped", 64'(o_intr_req), 64'(0));
        check("t3_valid_low", 64'(o_pcie_str_data_valid), 64'(0));
        rd_expect("t3_status_idle", 20'h10, 32'h0002_0000);
        rd_expect("t3_count", 20'h8, 32'd0);
        rd_expect("t3_ctrl", 20'h0, 32'd0);

        // KEY / data path, LEN=0 never interrupts
        wr(20'h4, 32'd0);
        wr(20'hC, 32'hFFFF_0000);
        i_pcie_str_ack = 1'b0;
        wr(20'h0, 32'h1);
        push_words(1, 64'h0);
        i_pcie_str_data_valid = 1'b0;
        check("t4_latency_valid", 64'(o_pcie_str_data_valid), 64'(1));
`ifdef STRM_XOR_EN
        check("t4_xor_data", o_pcie_str_data, 64'hFFFF_0000_FFFF_0000);
        rd_expect("t4_key", 20'hC, 32'hFFFF_0000);
`else
        check("t4_pass_data", o_pcie_str_data, 64'h0);
        rd_expect("t4_key", 20'hC, 32'h0);
`endif
        i_pcie_str_ack = 1'b1;
        push_words(6, 64'hC000);
        i_pcie_str_data_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("t4_no_intr", 64'(o_intr_req), 64'(0));
        rd_expect("t4_count", 20'h8, 32'd7);

        // Reset while handshakes are active
        i_pcie_str_ack = 1'b0;
        push_words(3, 64'hD000);
        i_pcie_str_ack = 1'b1;
        i_pcie_str_data_valid = 1'b1;
        i_rst = 1'b0;
        tick();
        check("t5_in_ack",  64'(o_pcie_str_ack), 64'(0));
        check("t5_valid",   64'(o_pcie_str_data_valid), 64'(0));
        check("t5_data",    o_pcie_str_data, 64'h0);
        check("t5_intr",    64'(o_intr_req), 64'(0));
        check("t5_rd_ack",  64'(o_user_rd_ack), 64'(0));
        check("t5_rd_data", 64'(o_user_data), 64'(0));
        i_rst = 1'b1;
        i_pcie_str_data_valid = 1'b0;
        i_pcie_str_ack = 1'b0;
        rd_expect("t5_ctrl",     20'h0,  32'h0);
        rd_expect("t5_len",      20'h4,  32'h0);
        rd_expect("t5_count",    20'h8,  32'h0);
        rd_expect("t5_key",      20'hC,  32'h0);
        rd_expect("t5_status",   20'h10, 32'h0002_0000);
        rd_expect("t5_unmapped", 20'h14, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
